cipher_run_ctrl: RTL and testbench

Run sequencer for the ARM `top` cipher core. On a start pulse it latches the mode switches and decodes the cipher mode and its result address window. It then pulses the core's reset and watches the data-memory write port until every result byte of that mode has been written. It reports done, timeout or configuration error, so board logic and benches no longer hand-drive reset and count cycles.

---
 rtl/cipher_ctrl_pkg.sv | 36 +++
 rtl/cipher_mode_decode.sv | 59 +++++
 rtl/cipher_run_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_cipher_run_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cipher_ctrl_pkg.sv
// Shared types and window constants for the cipher run sequencer.
// Contents: cipher mode enum, sequencer state enum, per-mode result address windows.
// Consumers: cipher_mode_decode, cipher_run_ctrl (import cipher_ctrl_pkg::*).
package cipher_ctrl_pkg;

  typedef enum logic [2:0] {
    NEG     = 3'd0,
    SUM     = 3'd1,
    XOR0    = 3'd2,
    XOR2    = 3'd3,
    XOR4    = 3'd4,
    ILLEGAL = 3'd5
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESET   = 3'd1,
    ST_RUN     = 3'd2,
    ST_DONE    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_t;

  // Result windows: first data-memory address written by the core and
  // number of result bytes it produces in that mode.
  localparam logic [7:0] NEG_BASE  = 8'd1;
  localparam logic [2:0] NEG_LEN   = 3'd4;
  localparam logic [7:0] SUM_BASE  = 8'd5;
  localparam logic [2:0] SUM_LEN   = 3'd4;
  localparam logic [7:0] XOR0_BASE = 8'd9;
  localparam logic [2:0] XOR0_LEN  = 3'd5;
  localparam logic [7:0] XOR2_BASE = 8'd14;
  localparam logic [2:0] XOR2_LEN  = 3'd4;
  localparam logic [7:0] XOR4_BASE = 8'd18;
  localparam logic [2:0] XOR4_LEN  = 3'd4;

endpackage

// File: rtl/cipher_mode_decode.sv
// Purpose: map the board mode switches to a cipher mode and its result window.
// Latency: purely combinational, no state.
// Backpressure: none; the caller samples the outputs on its start pulse.
// Ports: switch1..switch5 in; mode, base, len, legal out.
module cipher_mode_decode
  import cipher_ctrl_pkg::*;
(
  input  logic       switch1,
  input  logic       switch2,
  input  logic       switch3,
  input  logic       switch4,
  input  logic       switch5,
  output mode_t      mode,
  output logic [7:0] base,
  output logic [2:0] len,
  output logic       legal
);

  logic [2:0] key;
  assign key = {switch1, switch2, switch3};

  // Negation beats sum, and both beat the XOR key.
  always_comb begin
    mode = ILLEGAL;
    base = '0;
    len  = '0;
    if (switch4) begin
      mode = NEG;
      base = NEG_BASE;
      len  = NEG_LEN;
    end else if (switch5) begin
      mode = SUM;
      base = SUM_BASE;
      len  = SUM_LEN;
    end else begin
      case (key)
        3'b000: begin
          mode = XOR0;
          base = XOR0_BASE;
          len  = XOR0_LEN;
        end
        3'b010: begin
          mode = XOR2;
          base = XOR2_BASE;
          len  = XOR2_LEN;
        end
        3'b100: begin
          mode = XOR4;
          base = XOR4_BASE;
          len  = XOR4_LEN;
        end
        default: mode = ILLEGAL;
      endcase
    end
  end

  assign legal = (mode != ILLEGAL);

endmodule

// File: rtl/cipher_run_ctrl.sv
// Purpose: sequence one cipher-core run: reset pulse, watch result writes, report done/timeout/cfg error.
// Latency: RUN begins RESET_CYCLES+1 cycles after start; status updates one cycle after the sampled write.
// Backpressure: none; start is ignored while busy, writes are observed and never stalled.
// Ports: clk, reset (sync, active-high), start, switch1..5, mem_write, data_adr, write_data in;
//        core_reset, busy, done, timeout, cfg_err, result_count, last_data out.
// Build option: define CIPHER_RUN_TIMEOUT_EN to add the RUN cycle budget and TIMEOUT state.
module cipher_run_ctrl
  import cipher_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES = 3,
  parameter int MAX_CYCLES   = 300,
  parameter int DATA_W       = 8,
  parameter int ADR_W        = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              switch1,
  input  logic              switch2,
  input  logic              switch3,
  input  logic              switch4,
  input  logic              switch5,
  input  logic              mem_write,
  input  logic [ADR_W-1:0]  data_adr,
  input  logic [DATA_W-1:0] write_data,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              cfg_err,
  output logic [2:0]        result_count,
  output logic [DATA_W-1:0] last_data
);

  localparam int RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  if (RESET_CYCLES < 1 || MAX_CYCLES < 1) begin : g_param_check
    $error("cipher_run_ctrl: RESET_CYCLES and MAX_CYCLES must both be at least 1");
  end

  state_t            state, state_n;
  mode_t             dec_mode;
  logic [7:0]        dec_base;
  logic [2:0]        dec_len;
  logic              dec_legal;
  logic [7:0]        base_q;
  logic [2:0]        len_q;
  logic [RST_W-1:0]  rst_cnt;
  logic [2:0]        rc_q;
  logic [DATA_W-1:0] last_q;
  logic              cfg_q;
  logic              launch, cfg_set, accept;
  logic              in_win;
  logic [ADR_W:0]    adr_ext, win_lo, win_hi;

  cipher_mode_decode u_decode (
    .switch1 (switch1),
    .switch2 (switch2),
    .switch3 (switch3),
    .switch4 (switch4),
    .switch5 (switch5),
    .mode    (dec_mode),
    .base    (dec_base),
    .len     (dec_len),
    .legal   (dec_legal)
  );

  // One extra bit so base+len-1 cannot wrap at the top of the address space.
  assign adr_ext = {1'b0, data_adr};
  assign win_lo  = (ADR_W+1)'(base_q);
  assign win_hi  = win_lo + (ADR_W+1)'(len_q) - (ADR_W+1)'(1);
  assign in_win  = (adr_ext >= win_lo) && (adr_ext <= win_hi);

`ifdef CIPHER_RUN_TIMEOUT_EN
  localparam int CYC_W = $clog2(MAX_CYCLES + 1);
  logic [CYC_W-1:0] cyc_q;
  logic             budget_end;

  // High during the MAX_CYCLES-th RUN cycle.
  assign budget_end = (cyc_q == CYC_W'(MAX_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || launch) begin
      cyc_q <= '0;
    end else if (state == ST_RUN) begin
      cyc_q <= cyc_q + CYC_W'(1);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n    = state;
    launch     = 1'b0;
    cfg_set    = 1'b0;
    accept     = 1'b0;
    core_reset = 1'b1;
    busy       = 1'b0;
    done       = 1'b0;
    timeout    = 1'b0;
    case (state)
      // Resting states all accept a new start; an illegal one parks in IDLE.
      ST_IDLE, ST_DONE, ST_TIMEOUT: begin
        done = (state == ST_DONE);
`ifdef CIPHER_RUN_TIMEOUT_EN
        timeout = (state == ST_TIMEOUT);
`endif
        launch  = start && dec_legal;
        cfg_set = start && (dec_mode == ILLEGAL);
        if (launch) begin
          state_n = ST_RESET;
        end else if (cfg_set) begin
          state_n = ST_IDLE;
        end
      end
      ST_RESET: begin
        busy = 1'b1;
        if (rst_cnt == RST_W'(RESET_CYCLES - 1)) begin
          state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        core_reset = 1'b0;
        busy       = 1'b1;
        accept     = mem_write && in_win;
        // Completion is checked first so a last write on the final budget cycle still counts.
        if (accept && (rc_q + 3'd1 == len_q)) begin
          state_n = ST_DONE;
        end
`ifdef CIPHER_RUN_TIMEOUT_EN
        else if (budget_end) begin
          state_n = ST_TIMEOUT;
        end
`endif
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q  <= '0;
      len_q   <= '0;
      rst_cnt <= '0;
      rc_q    <= '0;
      last_q  <= '0;
      cfg_q   <= 1'b0;
    end else begin
      if (launch) begin
        base_q  <= dec_base;
        len_q   <= dec_len;
        rst_cnt <= '0;
        rc_q    <= '0;
        cfg_q   <= 1'b0;
      end
      if (cfg_set) begin
        cfg_q <= 1'b1;
      end
      // Free-runs only while in RESET; relaunch clears it.
      if (state == ST_RESET) begin
        rst_cnt <= rst_cnt + RST_W'(1);
      end
      if (accept) begin
        rc_q   <= rc_q + 3'd1;
        last_q <= write_data;
      end
    end
  end

  assign cfg_err      = cfg_q;
  assign result_count = rc_q;
  assign last_data    = last_q;

endmodule

// File: tb/tb_cipher_run_ctrl.sv
module tb_cipher_run_ctrl;

  localparam int RC = 3;
  localparam int MC = 300;

`ifdef CIPHER_RUN_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  // Switch patterns packed as {switch1,switch2,switch3,switch4,switch5}.
  localparam logic [4:0] SW_NEG  = 5'b00010;
  localparam logic [4:0] SW_SUM  = 5'b00001;
  localparam logic [4:0] SW_XOR0 = 5'b00000;
  localparam logic [4:0] SW_BAD  = 5'b11100;

  logic       clk = 1'b0;
  logic       reset, start, mem_write;
  logic       switch1, switch2, switch3, switch4, switch5;
  logic [7:0] data_adr, write_data;
  logic       core_reset, busy, done, timeout, cfg_err;
  logic [2:0] result_count;
  logic [7:0] last_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cipher_run_ctrl #(
    .RESET_CYCLES (RC),
    .MAX_CYCLES   (MC),
    .DATA_W       (8),
    .ADR_W        (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .switch1      (switch1),
    .switch2      (switch2),
    .switch3      (switch3),
    .switch4      (switch4),
    .switch5      (switch5),
    .mem_write    (mem_write),
    .data_adr     (data_adr),
    .write_data   (write_data),
    .core_reset   (core_reset),
    .busy         (busy),
    .done         (done),
    .timeout      (timeout),
    .cfg_err      (cfg_err),
    .result_count (result_count),
    .last_data    (last_data)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  localparam int P_IDLE = 0, P_RST = 1, P_RUN = 2, P_DONE = 3, P_TMO = 4;
  int m_phase = P_IDLE;
  int m_cnt   = 0;
  int m_rc    = 0;
  int m_last  = 0;
  int m_base  = 0;
  int m_len   = 0;
  bit m_cfg   = 1'b0;
  bit m_on    = 1'b0;

  function automatic bit mode_window(input logic [4:0] s, output int base, output int len);
    base = 0;
    len  = 0;
    if (s[1]) begin base = 1; len = 4; return 1'b1; end
    if (s[0]) begin base = 5; len = 4; return 1'b1; end
    case (s[4:2])
      3'b000: begin base = 9;  len = 5; return 1'b1; end
      3'b010: begin base = 14; len = 4; return 1'b1; end
      3'b100: begin base = 18; len = 4; return 1'b1; end
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    int b, l;
    if (reset) begin
      m_on = 1'b1; m_phase = P_IDLE; m_rc = 0; m_last = 0; m_cfg = 1'b0;
    end else if (m_on) begin
      if (m_phase == P_IDLE || m_phase == P_DONE || m_phase == P_TMO) begin
        if (start) begin
          if (mode_window({switch1, switch2, switch3, switch4, switch5}, b, l)) begin
            m_phase = P_RST; m_cnt = 0; m_rc = 0; m_cfg = 1'b0; m_base = b; m_len = l;
          end else begin
            m_cfg = 1'b1; m_phase = P_IDLE;
          end
        end
      end else if (m_phase == P_RST) begin
        m_cnt++;
        if (m_cnt == RC) begin m_phase = P_RUN; m_cnt = 0; end
      end else begin
        m_cnt++;
        if (mem_write && int'(data_adr) >= m_base && int'(data_adr) < m_base + m_len) begin
          m_rc++;
          m_last = int'(write_data);
        end
        if (m_rc == m_len) m_phase = P_DONE;
        else if (TMO_EN && m_cnt == MC) m_phase = P_TMO;
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      check("core_reset", int'(core_reset), int'(m_phase != P_RUN));
      check("busy", int'(busy), int'(m_phase == P_RST || m_phase == P_RUN));
      check("done", int'(done), int'(m_phase == P_DONE));
      check("timeout", int'(timeout), int'(m_phase == P_TMO));
      check("cfg_err", int'(cfg_err), int'(m_cfg));
      check("result_count", int'(result_count), m_rc);
      check("last_data", int'(last_data), m_last);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Drive one cycle of inputs; on return the DUT has sampled them.
  task automatic step(input bit st, input bit mw, input int adr, input int wd);
    start = st; mem_write = mw; data_adr = 8'(adr); write_data = 8'(wd);
    @(negedge clk);
  endtask

  task automatic set_sw(input logic [4:0] s);
    {switch1, switch2, switch3, switch4, switch5} = s;
  endtask

  task automatic launch(input logic [4:0] s);
    set_sw(s);
    step(1'b1, 1'b0, 0, 0);
  endtask

  task automatic wait_run();
    int i = 0;
    while (core_reset && i < 20) begin
      step(1'b0, 1'b0, 0, 0);
      i++;
    end
    check("reach_run", int'(core_reset), 0);
    check("reset_length", i, RC);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mem_write = 1'b0; data_adr = '0; write_data = '0;
    set_sw(5'b0);
    step(1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 0, 0);
    reset = 1'b0;
    check("rst_core_reset", int'(core_reset), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_cfg_err", int'(cfg_err), 0);
    check("rst_result_count", int'(result_count), 0);

    // NEG run
    launch(SW_NEG);
    check("neg_busy_in_reset", int'(busy), 1);
    wait_run();
    step(1'b0, 1'b1, 1, 67);
    step(1'b0, 1'b1, 2, 65);
    step(1'b0, 1'b1, 3, 83);
    check("neg_not_done_yet", int'(done), 0);
    step(1'b0, 1'b1, 4, 65);
    check("neg_done", int'(done), 1);
    check("neg_count", int'(result_count), 4);
    check("neg_last", int'(last_data), 65);
    check("neg_core_reset", int'(core_reset), 1);
    step(1'b0, 1'b0, 0, 0);

    // XOR key 000 with a stray write, relaunched from DONE
    launch(SW_XOR0);
    wait_run();
    step(1'b0, 1'b1, 9, 76);
    step(1'b0, 1'b1, 10, 73);
    step(1'b0, 1'b1, 30, 99);
    step(1'b0, 1'b1, 11, 66);
    step(1'b0, 1'b1, 12, 82);
    check("xor0_count_after_stray", int'(result_count), 4);
    step(1'b0, 1'b1, 13, 79);
    check("xor0_done", int'(done), 1);
    check("xor0_count", int'(result_count), 5);
    check("xor0_last", int'(last_data), 79);

    // Illegal key
    set_sw(SW_BAD);
    step(1'b1, 1'b0, 0, 0);
    check("bad_cfg_err", int'(cfg_err), 1);
    check("bad_busy", int'(busy), 0);
    check("bad_core_reset", int'(core_reset), 1);
    step(1'b0, 1'b0, 0, 0);

    // Reset in the middle of a NEG run, then a clean rerun
    launch(SW_NEG);
    check("cfg_err_cleared", int'(cfg_err), 0);
    wait_run();
    step(1'b0, 1'b1, 1, 5);
    step(1'b0, 1'b1, 2, 6);
    check("mid_count", int'(result_count), 2);
    reset = 1'b1;
    step(1'b0, 1'b0, 0, 0);
    reset = 1'b0;
    check("mid_rst_count", int'(result_count), 0);
    check("mid_rst_core_reset", int'(core_reset), 1);
    check("mid_rst_busy", int'(busy), 0);
    launch(SW_NEG);
    wait_run();
    for (int a = 1; a <= 4; a++) step(1'b0, 1'b1, a, 10 * a);
    check("rerun_done", int'(done), 1);
    check("rerun_last", int'(last_data), 40);

    // start and switch changes during RUN are ignored
    launch(SW_SUM);
    wait_run();
    set_sw(SW_NEG);
    step(1'b1, 1'b1, 5, 11);
    set_sw(SW_BAD);
    step(1'b1, 1'b1, 1, 99);
    step(1'b0, 1'b1, 6, 12);
    check("sum_count_kept_mode", int'(result_count), 2);
    check("sum_busy", int'(busy), 1);
    check("sum_no_cfg_err", int'(cfg_err), 0);
    step(1'b0, 1'b1, 7, 13);
    step(1'b0, 1'b1, 8, 14);
    check("sum_done", int'(done), 1);
    check("sum_last", int'(last_data), 14);

`ifdef CIPHER_RUN_TIMEOUT_EN
    // Budget exhaustion with no in-window writes
    launch(SW_SUM);
    wait_run();
    begin
      int n = 0;
      while (!timeout && !done && n < 400) begin
        step(1'b0, 1'b0, 0, 0);
        n++;
      end
      check("timeout_run_cycles", n, MC);
    end
    check("tmo_timeout", int'(timeout), 1);
    check("tmo_done", int'(done), 0);
    check("tmo_core_reset", int'(core_reset), 1);

    // Last write lands on the final budget cycle: done wins
    launch(SW_SUM);
    wait_run();
    step(1'b0, 1'b1, 5, 1);
    step(1'b0, 1'b1, 6, 2);
    step(1'b0, 1'b1, 7, 3);
    repeat (MC - 4) step(1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b1, 8, 77);
    check("tie_done", int'(done), 1);
    check("tie_timeout", int'(timeout), 0);
    check("tie_last", int'(last_data), 77);
`else
    // Without the budget RUN waits indefinitely
    launch(SW_SUM);
    wait_run();
    repeat (1000) step(1'b0, 1'b0, 0, 0);
    check("notmo_busy", int'(busy), 1);
    check("notmo_core_reset", int'(core_reset), 0);
    check("notmo_timeout", int'(timeout), 0);
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 9) == 0) set_sw(5'($urandom));
      reset = ($urandom_range(0, 399) == 0);
      step($urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 23)), int'($urandom_range(0, 255)));
    end
    reset = 1'b0;
    step(1'b0, 1'b0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
